// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the 32-bit-word to 16-bit SRAM controller:
//   - FSM state encoding (IDLE, LO, HI, DONE)
//   - SRAM bus widths (18-bit half-word address, 16-bit data)
//   - CPU-side data width and the default byte address of SRAM half-word 0
//   - hw_index(): byte address -> even SRAM half-word index
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam int unsigned CPU_DATA_W        = 32;
    localparam int unsigned ADDR_BASE_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A 32-bit word occupies two consecutive half-words starting at an even
    // index. Anything beyond the 18-bit SRAM space wraps silently.
    function automatic logic [SRAM_ADDR_W-1:0] hw_index(
        input logic [CPU_DATA_W-1:0] addr,
        input logic [CPU_DATA_W-1:0] base
    );
        return SRAM_ADDR_W'(((addr - base) >> 1) & ~32'd1);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_ctrl_if
// Pipeline-side memory request bus between the MEM stage and sram_ctrl.
//   rdEn      : load request
//   wrEn      : store request (wins over rdEn)
//   address   : word-aligned byte address
//   writeData : store data
//   readData  : load result, valid while ready=1 in DONE
//   ready     : 0 freezes the pipeline
// Modports: master = MEM stage, slave = controller.
// -----------------------------------------------------------------------------
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic                  rdEn;
    logic                  wrEn;
    logic [CPU_DATA_W-1:0] address;
    logic [CPU_DATA_W-1:0] writeData;
    logic [CPU_DATA_W-1:0] readData;
    logic                  ready;

    modport master (
        output rdEn,
        output wrEn,
        output address,
        output writeData,
        input  readData,
        input  ready
    );

    modport slave (
        input  rdEn,
        input  wrEn,
        input  address,
        input  writeData,
        output readData,
        output ready
    );

endinterface

// File: rtl/sram_wait_cnt.sv
// -----------------------------------------------------------------------------
// sram_wait_cnt
// Down-counter that stretches each SRAM half-word phase. Only instantiated
// when SRAM_CTRL_WAIT_EN is defined.
//   clk        : clock
//   rst        : synchronous active-high reset (count -> 0)
//   i_load     : load i_load_val (asserted on phase entry)
//   i_load_val : number of extra cycles to hold the phase
//   o_zero     : count has reached zero -> current cycle is the phase's last
// -----------------------------------------------------------------------------
module sram_wait_cnt
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
// Bridges 32-bit loads/stores from the MEM stage to a 16-bit asynchronous
// SRAM by splitting every word into a low (LO) and high (HI) half-word
// phase. The pipeline is frozen (ready=0) until the access reaches DONE.
//
// Parameters:
//   ADDR_BASE   : byte address that maps to SRAM half-word 0
//   WAIT_CYCLES : extra cycles per half-word phase (SRAM_CTRL_WAIT_EN only)
//
// Optional feature macro: SRAM_CTRL_WAIT_EN
//   defined   : LO and HI each last 1+WAIT_CYCLES cycles (sram_wait_cnt)
//   undefined : LO and HI last one cycle each, no counter
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : sram_ctrl_if.slave (rdEn, wrEn, address, writeData,
//                readData, ready)
//   SRAM_DQ    : 16-bit bidirectional SRAM data, driven only while writing
//   SRAM_ADDR  : 18-bit SRAM half-word address
//   SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N : active-low
// -----------------------------------------------------------------------------
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_ctrl_if.slave             bus,
    inout  wire [SRAM_DATA_W-1:0]  SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_op_wr;
    logic [SRAM_ADDR_W-1:0]  r_hw;
    logic [CPU_DATA_W-1:0]   r_wdata;
    logic [SRAM_DATA_W-1:0]  r_rd_lo;
    logic [CPU_DATA_W-1:0]   r_read_data;

    logic                    w_req;
    logic                    w_start;
    logic                    w_phase_last;
    logic                    w_ready;
    logic                    w_active;
    logic [SRAM_ADDR_W-1:0]  w_sram_addr;
    logic [SRAM_DATA_W-1:0]  w_dq_out;
    logic                    w_dq_oe;

    assign w_req   = bus.rdEn | bus.wrEn;
    assign w_start = (r_state == ST_IDLE) && w_req;

`ifdef SRAM_CTRL_WAIT_EN
    localparam int unsigned CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic w_cnt_load;
    logic w_cnt_zero;

    // Reload on every entry into LO or HI so both phases get the full hold.
    assign w_cnt_load = (w_state_next != r_state) &&
                        ((w_state_next == ST_LO) || (w_state_next == ST_HI));

    sram_wait_cnt #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (CNT_W'(WAIT_CYCLES)),
        .o_zero     (w_cnt_zero)
    );

    assign w_phase_last = w_cnt_zero;
`else
    // Single-cycle phases. WAIT_CYCLES has no effect in this build; it is
    // folded into a tie-off so the parameter is still referenced.
    logic w_unused;
    assign w_unused     = &{1'b0, (WAIT_CYCLES != 0)};
    assign w_phase_last = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and SRAM-side outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_active     = 1'b0;
        w_sram_addr  = '0;
        w_dq_out     = '0;

        case (r_state)
            ST_IDLE: begin
                w_ready = !w_req;
                if (w_req) begin
                    w_state_next = ST_LO;
                end
            end
            ST_LO: begin
                w_active    = 1'b1;
                w_sram_addr = r_hw;
                w_dq_out    = r_wdata[15:0];
                if (w_phase_last) begin
                    w_state_next = ST_HI;
                end
            end
            ST_HI: begin
                w_active    = 1'b1;
                // r_hw is always even, so setting bit 0 is hw+1.
                w_sram_addr = {r_hw[SRAM_ADDR_W-1:1], 1'b1};
                w_dq_out    = r_wdata[31:16];
                if (w_phase_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ready      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Reset is synchronous for state, but the SRAM pins and ready must
        // already look idle while rst is held.
        if (rst) begin
            w_ready  = 1'b1;
            w_active = 1'b0;
        end
    end

    assign w_dq_oe   = w_active && r_op_wr;

    assign SRAM_ADDR = w_sram_addr;
    assign SRAM_CE_N = !w_active;
    assign SRAM_UB_N = !w_active;
    assign SRAM_LB_N = !w_active;
    assign SRAM_WE_N = !(w_active && r_op_wr);
    assign SRAM_OE_N = !(w_active && !r_op_wr);
    assign SRAM_DQ   = w_dq_oe ? w_dq_out : {SRAM_DATA_W{1'bz}};

    assign bus.ready    = w_ready;
    assign bus.readData = r_read_data;

    // -------------------------------------------------------------------------
    // Request latch and read capture
    // -------------------------------------------------------------------------
    // The low half is parked in r_rd_lo so readData only changes once the
    // whole word is in; an aborted read never leaves a half-updated word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_wr     <= 1'b0;
            r_hw        <= '0;
            r_wdata     <= '0;
            r_rd_lo     <= '0;
            r_read_data <= '0;
        end else begin
            if (w_start) begin
                r_op_wr <= bus.wrEn;
                r_hw    <= hw_index(bus.address, ADDR_BASE);
                r_wdata <= bus.writeData;
            end
            if ((r_state == ST_LO) && w_phase_last && !r_op_wr) begin
                r_rd_lo <= SRAM_DQ;
            end
            if ((r_state == ST_HI) && w_phase_last && !r_op_wr) begin
                r_read_data <= {SRAM_DQ, r_rd_lo};
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_ctrl
// Self-checking bench for sram_ctrl. A 256K x 16 SRAM model sits on the pins;
// expected results come from a word-level reference (half-word map keyed by
// index, computed from the address rule with plain arithmetic).
// -----------------------------------------------------------------------------
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int unsigned BASE = 1024;
    localparam int unsigned WC   = 2;
`ifdef SRAM_CTRL_WAIT_EN
    localparam int PH = 1 + WC;
`else
    localparam int PH = 1;
`endif
    localparam int LAT = 2 * PH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if bus();

    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

    sram_ctrl #(
        .ADDR_BASE   (BASE),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N)
    );

    // SRAM device model
    logic [15:0] sram_mem [0:262143];
    assign SRAM_DQ = (!SRAM_OE_N && !SRAM_CE_N) ? sram_mem[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) sram_mem[SRAM_ADDR] <= SRAM_DQ;
    end

    // Reference model
    logic [15:0] ref_half [int];
    logic [31:0] last_rd;
    int errors = 0;
    int checks = 0;

    function automatic int ref_hw(input logic [31:0] addr);
        logic [31:0] offset;
        int h;
        offset = addr - 32'(BASE);
        h = int'((offset / 32'd2) % 32'd262144);
        return h - (h % 2);
    endfunction

    function automatic logic [15:0] ref_get(input int h);
        return ref_half.exists(h) ? ref_half[h] : 16'h0000;
    endfunction

    // One complete access with per-cycle pin and handshake checks.
    task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit scramble,
                             input bit hold, input string tag);
        int          h;
        bit          is_wr;
        logic [31:0] exp_rd;
        logic [31:0] exp_data;
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        logic [4:0]  exp_ctl;
        logic [4:0]  ctl;
        logic        exp_ready;
        h      = ref_hw(addr);
        is_wr  = wr;
        exp_rd = {ref_get(h + 1), ref_get(h)};
        bus.rdEn = rd; bus.wrEn = wr; bus.address = addr; bus.writeData = wdata;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL %s req_ready: got %b expected 0", tag, bus.ready);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            exp_ready = (k == LAT);
            checks++;
            if (bus.ready !== exp_ready) begin
                errors++;
                $display("FAIL %s ready_c%0d: got %b expected %b", tag, k, bus.ready, exp_ready);
            end
            if (k < LAT) begin
                exp_addr = 18'((k <= PH) ? h : h + 1);
                checks++;
                if (SRAM_ADDR !== exp_addr) begin
                    errors++;
                    $display("FAIL %s addr_c%0d: got %0d expected %0d", tag, k, SRAM_ADDR, exp_addr);
                end
                exp_ctl = {3'b000, ~is_wr, is_wr};
                ctl = {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
                checks++;
                if (ctl !== exp_ctl) begin
                    errors++;
                    $display("FAIL %s ctl_c%0d: got %b expected %b", tag, k, ctl, exp_ctl);
                end
                if (is_wr) begin
                    exp_dq = (k <= PH) ? wdata[15:0] : wdata[31:16];
                    checks++;
                    if (SRAM_DQ !== exp_dq) begin
                        errors++;
                        $display("FAIL %s dq_c%0d: got %h expected %h", tag, k, SRAM_DQ, exp_dq);
                    end
                end
            end else begin
                exp_data = is_wr ? last_rd : exp_rd;
                checks++;
                if (bus.readData !== exp_data) begin
                    errors++;
                    $display("FAIL %s readData: got %h expected %h", tag, bus.readData, exp_data);
                end
            end
            if (scramble && k == 1) begin
                bus.rdEn = 1'($urandom_range(0, 1));
                bus.wrEn = 1'($urandom_range(0, 1));
                bus.address = $urandom;
                bus.writeData = $urandom;
            end
        end
        if (is_wr) begin
            ref_half[h]     = wdata[15:0];
            ref_half[h + 1] = wdata[31:16];
            checks++;
            if ({sram_mem[h + 1], sram_mem[h]} !== {ref_get(h + 1), ref_get(h)}) begin
                errors++;
                $display("FAIL %s sram_word: got %h%h expected %h", tag, sram_mem[h + 1], sram_mem[h], wdata);
            end
        end else begin
            last_rd = exp_rd;
        end
        if (hold) begin
            @(posedge clk); #1;
            checks++;
            if (bus.ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold_restart: got ready %b expected 0", tag, bus.ready);
            end
        end else begin
            bus.rdEn = 1'b0; bus.wrEn = 1'b0;
            @(posedge clk); #1;
            ctl = {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
            checks++;
            if (bus.ready !== 1'b1 || ctl !== 5'b11111) begin
                errors++;
                $display("FAIL %s idle_after: got ready %b ctl %b expected 1 11111", tag, bus.ready, ctl);
            end
        end
        $display("txn %s: %s addr=%h wdata=%h readData=%h", tag, is_wr ? "WR" : "RD", addr, wdata, bus.readData);
    endtask

    task automatic test_reset();
        logic [4:0] ctl;
        rst = 1'b1; bus.rdEn = 1'b1; bus.wrEn = 1'b0; bus.address = BASE; bus.writeData = '0;
        repeat (2) @(posedge clk);
        #1;
        ctl = {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", bus.ready); end
        checks++;
        if (ctl !== 5'b11111) begin errors++; $display("FAIL rst_ctl: got %b expected 11111", ctl); end
        bus.rdEn = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        ctl = {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", bus.ready); end
        checks++;
        if (bus.readData !== 32'h0) begin errors++; $display("FAIL post_rst_readData: got %h expected 0", bus.readData); end
        checks++;
        if (ctl !== 5'b11111) begin errors++; $display("FAIL post_rst_ctl: got %b expected 11111", ctl); end
        $display("txn reset: ready=%b readData=%h", bus.ready, bus.readData);
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, "wr_deadbeef");
        checks++;
        if (sram_mem[0] !== 16'hBEEF || sram_mem[1] !== 16'hDEAD) begin
            errors++;
            $display("FAIL hw01: got %h %h expected beef dead", sram_mem[0], sram_mem[1]);
        end
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, 1'b0, "rd_deadbeef");
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, 1'b0, "rd_1032");
    endtask

    task automatic test_both();
        do_access(1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b0, 1'b0, "both_1028");
        checks++;
        if (sram_mem[2] !== 16'h5678 || sram_mem[3] !== 16'h1234) begin
            errors++;
            $display("FAIL hw23: got %h %h expected 5678 1234", sram_mem[2], sram_mem[3]);
        end
    endtask

    task automatic test_wrap();
        do_access(1'b1, 1'b0, 32'(BASE) - 32'd4, 32'hCAFEF00D, 1'b0, 1'b0, "wr_below_base");
        do_access(1'b0, 1'b1, 32'(BASE) - 32'd4, 32'h0, 1'b0, 1'b0, "rd_below_base");
        do_access(1'b1, 1'b0, 32'(BASE) + 32'h80000, 32'hA5A55A5A, 1'b0, 1'b0, "wr_wrap_top");
        do_access(1'b0, 1'b1, 32'(BASE), 32'h0, 1'b0, 1'b0, "rd_base_after_wrap");
    endtask

    task automatic test_reset_mid();
        logic [4:0] ctl;
        do_access(1'b0, 1'b1, 32'(BASE), 32'h0, 1'b0, 1'b0, "rd_before_abort");
        bus.rdEn = 1'b1; bus.address = BASE;
        repeat (PH + 1) @(posedge clk);
        #1;
        checks++;
        if (SRAM_ADDR !== 18'd1) begin errors++; $display("FAIL abort_in_hi: got addr %0d expected 1", SRAM_ADDR); end
        rst = 1'b1; bus.rdEn = 1'b0;
        #1;
        ctl = {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
        checks++;
        if (bus.ready !== 1'b1 || ctl !== 5'b11111) begin
            errors++;
            $display("FAIL abort_during_rst: got ready %b ctl %b expected 1 11111", bus.ready, ctl);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        last_rd = 32'h0;
        ctl = {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_OE_N};
        checks++;
        if (bus.ready !== 1'b1 || bus.readData !== last_rd || ctl !== 5'b11111) begin
            errors++;
            $display("FAIL abort_after: got ready %b readData %h ctl %b expected 1 %h 11111", bus.ready, bus.readData, ctl, last_rd);
        end
        $display("txn abort: ready=%b readData=%h", bus.ready, bus.readData);
        // The cycle is mid-period here; realign to #1 after an edge.
        @(posedge clk); #1;
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0, "rd_after_abort");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b1, "b2b_first");
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 1'b0, "b2b_second");
        do_access(1'b1, 1'b0, 32'd1036, 32'h0BADC0DE, 1'b0, 1'b1, "b2b_wr_first");
        do_access(1'b1, 1'b0, 32'd1036, 32'h0BADC0DE, 1'b0, 1'b0, "b2b_wr_second");
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          w, r;
        for (int i = 0; i < 32; i++) begin
            do_access(1'b1, 1'b0, 32'(BASE) + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 1'b0,
                      $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            a = 32'(BASE) + 32'(4 * $urandom_range(0, 31));
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            do_access(w, r, a, $urandom, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        last_rd = 32'h0;
        bus.rdEn = 1'b0; bus.wrEn = 1'b0; bus.address = '0; bus.writeData = '0;
        test_reset();
        test_write_read();
        test_both();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: ADDR_BASE, 1024, byte address mapped to SRAM half-word 0.
REQ-002 Parameter: WAIT_CYCLES, 1, extra hold cycles per half-word phase; used only with SRAM_CTRL_WAIT_EN.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 rdEn  in  1  load request from the MEM stage (memReadEn carried down the pipeline).
REQ-006 wrEn  in  1  store request from the MEM stage (memWriteEn carried down the pipeline).
REQ-007 address  in  32  byte address of the word; word-aligned.
REQ-008 writeData  in  32  store data.
REQ-009 readData  out  32  load result; valid while ready=1 in DONE.
REQ-010 ready  out  1  0 = freeze the pipeline; 1 = the access has completed or there is no access.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  out  18  SRAM half-word address.
REQ-013 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.

Function
REQ-014 The controller SHALL use an FSM with states IDLE, LO, HI and DONE, plus a per-access flag op_wr.
REQ-015 ready SHALL be combinational: 1 when (IDLE and no rdEn/wrEn) or in DONE, otherwise 0.
REQ-016 In IDLE, if rdEn or wrEn is set, the FSM SHALL go to LO and latch op_wr=wrEn; wrEn wins when both are set.
REQ-017 Half-word index hw = (address - ADDR_BASE) >> 1, truncated to 18 bits, with bit0 forced to 0.
REQ-018 In LO, SRAM_ADDR SHALL be hw and the low half-word SHALL be transferred.
REQ-019 In HI, SRAM_ADDR SHALL be hw+1 and the high half-word SHALL be transferred.
REQ-020 Read: OE_N=0 in LO/HI; DQ is sampled on the last cycle of the phase into readData[15:0] (LO) or readData[31:16] (HI).
REQ-021 Write: WE_N=0 in LO/HI and DQ is driven with writeData[15:0] (LO) or writeData[31:16] (HI).
REQ-022 DQ SHALL be high-Z at all times except during write phases.
REQ-023 CE_N, UB_N and LB_N SHALL be 0 in LO and HI, and 1 otherwise.
REQ-024 WE_N and OE_N SHALL be 1 outside their active phases.
REQ-025 DONE SHALL last exactly one cycle, then go to IDLE; readData SHALL hold until the next read completes.
REQ-026 Without wait states, ready SHALL rise 3 cycles after the request appears in IDLE.
REQ-027 With wait states, ready SHALL rise 2*(1+WAIT_CYCLES)+1 cycles after the request appears in IDLE.
REQ-028 Deassertion or change of rdEn, wrEn, address or writeData after leaving IDLE SHALL be ignored; address and data are latched on the IDLE->LO transition.
REQ-029 A request still present when the FSM re-enters IDLE after DONE SHALL start a new access.
REQ-030 Address wrap-around above 2^18 half-words SHALL truncate silently; no error output exists.

Reset
REQ-031 On rst: state=IDLE, op_wr=0, readData=0, wait counter=0, latched address/data=0.
REQ-032 While rst=1, ready SHALL be 1 and DQ SHALL be high-Z.
REQ-033 While rst=1, WE_N, OE_N, CE_N, UB_N and LB_N SHALL all be 1.
REQ-034 rst mid-access SHALL abort the access on that edge with no partial readData update.

Configuration
REQ-035 Macro SRAM_CTRL_WAIT_EN defined: each of LO and HI SHALL last 1+WAIT_CYCLES cycles, using a down-counter loaded on phase entry.
REQ-036 Macro SRAM_CTRL_WAIT_EN undefined: LO and HI SHALL last 1 cycle each, and no counter SHALL be synthesized.

Structure
REQ-037 Package sram_ctrl_pkg SHALL hold the state encoding, SRAM_ADDR_W=18, SRAM_DATA_W=16 and the ADDR_BASE default.
REQ-038 The wait counter SHALL be sub-module sram_wait_cnt, instantiated only under SRAM_CTRL_WAIT_EN.

Verification
REQ-039 Macro off, write 0xDEADBEEF to 1024 -> SRAM half-word 0=0xBEEF, half-word 1=0xDEAD, and ready rises on cycle 3.
REQ-040 Macro off, read 1024 after REQ-039 -> readData=0xDEADBEEF in DONE; DQ is never driven by the controller.
REQ-041 Macro on, WAIT_CYCLES=2, read 1032 -> SRAM_ADDR=4 for 3 cycles, then 5 for 3 cycles, and ready rises on cycle 7.
REQ-042 rdEn=wrEn=1 at 1028 with writeData=0x12345678 -> a write is performed; half-words 2 and 3 = 0x5678 and 0x1234.
REQ-043 rst pulsed during HI of a read -> next cycle IDLE, ready=1, readData=0, and all SRAM controls=1.
REQ-044 Request held after DONE -> a second identical access starts; readData and ready match a fresh access.
